// File: rtl/vram_fill_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : vram_fill_arbiter_if
//  Purpose  : Bundles the fill request, CPU write port and VRAM write port
//             of the VRAM fill arbiter into one interface.
//  Revision : 1.0 - initial release
// ============================================================================
interface vram_fill_arbiter_if;
   // fill request
   logic        iStart;
   logic [5:0]  iRow0;
   logic [6:0]  iCol0;
   logic [5:0]  iHeight;
   logic [6:0]  iWidth;
   logic [2:0]  iColor;
   // CPU write port
   logic        iCpuWe;
   logic [12:0] iCpuAddr;
   logic [2:0]  iCpuData;
   // VRAM write port and status
   logic        oVramWe;
   logic [12:0] oVramAddr;
   logic [2:0]  oVramData;
   logic        oBusy;
   logic        oDone;

   // requester side (drives the fill request and CPU writes)
   modport master (
      output iStart, iRow0, iCol0, iHeight, iWidth, iColor,
      output iCpuWe, iCpuAddr, iCpuData,
      input  oVramWe, oVramAddr, oVramData, oBusy, oDone
   );

   // arbiter side
   modport slave (
      input  iStart, iRow0, iCol0, iHeight, iWidth, iColor,
      input  iCpuWe, iCpuAddr, iCpuData,
      output oVramWe, oVramAddr, oVramData, oBusy, oDone
   );
endinterface
`default_nettype wire

// File: rtl/vram_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_fill_arbiter
//  Purpose  : Rectangle fill engine sharing a single VRAM write port with a
//             CPU. CPU writes always win and stall the fill; pixels outside
//             the visible COLS x ROWS area are skipped but still consume a
//             cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module vram_fill_arbiter #(
   parameter int unsigned COLS = 80,   // visible columns (must be < 256)
   parameter int unsigned ROWS = 60    // visible rows (must be < 128)
) (
   input  wire logic          Clock,
   input  wire logic          Reset,
   vram_fill_arbiter_if.slave bus
);

   localparam logic [7:0] C_COLS = 8'(COLS);
   localparam logic [6:0] C_ROWS = 7'(ROWS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   // counters are one bit wider than the address fields so that a rectangle
   // running off the right/bottom edge never wraps back into visible VRAM
   logic [6:0]  row_q, row_d;
   logic [7:0]  col_q, col_d;
   logic [5:0]  row0_q, row0_d;
   logic [6:0]  col0_q, col0_d;
   logic [5:0]  height_q, height_d;
   logic [6:0]  width_q, width_d;
   logic [2:0]  color_q, color_d;

   logic [7:0]  end_col;
   logic [6:0]  end_row;
   logic        pix_in_range;

   // last column/row of the latched rectangle (only used while W,H > 0)
   assign end_col      = {1'b0, col0_q} + {1'b0, width_q} - 8'd1;
   assign end_row      = {1'b0, row0_q} + {1'b0, height_q} - 7'd1;
   assign pix_in_range = (row_q < C_ROWS) && (col_q < C_COLS);

   // state, counter and parameter registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= IDLE;
         row_q    <= '0;
         col_q    <= '0;
         row0_q   <= '0;
         col0_q   <= '0;
         height_q <= '0;
         width_q  <= '0;
         color_q  <= '0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         row0_q   <= row0_d;
         col0_q   <= col0_d;
         height_q <= height_d;
         width_q  <= width_d;
         color_q  <= color_d;
      end
   end

   // next-state: latch request in IDLE, raster-scan the rectangle in FILL
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      row0_d   = row0_q;
      col0_d   = col0_q;
      height_d = height_q;
      width_d  = width_q;
      color_d  = color_q;
      case (state_q)
         IDLE: begin
            if (bus.iStart) begin
               row0_d   = bus.iRow0;
               col0_d   = bus.iCol0;
               height_d = bus.iHeight;
               width_d  = bus.iWidth;
               color_d  = bus.iColor;
               row_d    = {1'b0, bus.iRow0};
               col_d    = {1'b0, bus.iCol0};
               state_d  = ((bus.iHeight != 6'd0) && (bus.iWidth != 7'd0)) ? FILL : DONE;
            end
         end
         FILL: begin
            // a CPU write owns the port this cycle, so the scan position holds
            if (!bus.iCpuWe) begin
               if (col_q == end_col) begin
                  col_d = {1'b0, col0_q};
                  if (row_q == end_row) begin
                     state_d = DONE;
                  end else begin
                     row_d = row_q + 7'd1;
                  end
               end else begin
                  col_d = col_q + 8'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // VRAM port mux: reset blocks everything, CPU beats fill, idle drives zero
   always_comb begin
      bus.oVramWe   = 1'b0;
      bus.oVramAddr = '0;
      bus.oVramData = '0;
      if (!Reset) begin
         if (bus.iCpuWe) begin
            bus.oVramWe   = 1'b1;
            bus.oVramAddr = bus.iCpuAddr;
            bus.oVramData = bus.iCpuData;
         end else if ((state_q == FILL) && pix_in_range) begin
            bus.oVramWe   = 1'b1;
            bus.oVramAddr = {row_q[5:0], col_q[6:0]};
            bus.oVramData = color_q;
         end
      end
   end

   assign bus.oBusy = (state_q != IDLE);
   assign bus.oDone = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_vram_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_fill_arbiter
//  Purpose  : Self-checking bench for vram_fill_arbiter. A behavioural model
//             expands each accepted request into the list of pixels it must
//             produce and is compared against the DUT every cycle; directed
//             scenarios additionally pin literal write sequences and timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vram_fill_arbiter;
   localparam int COLS = 80;
   localparam int ROWS = 60;

   logic Clock = 1'b0;
   logic Reset;

   vram_fill_arbiter_if bus ();

   vram_fill_arbiter #(.COLS(COLS), .ROWS(ROWS)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit          valid;
      logic [12:0] addr;
   } pix_t;

   int          m_mode = 0;      // 0 idle, 1 filling, 2 done pulse
   pix_t        m_pix[$];
   int          m_idx  = 0;
   logic [2:0]  m_color = '0;

   // observation logs for directed scenarios
   logic [12:0] wlog[$];
   int          busy_cnt = 0;
   int          done_cnt = 0;
   int          cpu_cnt  = 0;
   int          cyc      = 0;
   int          last_wr  = 0;
   int          done_cyc = 0;

   task automatic build_list(input int r0, input int c0, input int h, input int w);
      m_pix.delete();
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            pix_t p;
            p.valid = ((r0 + r) < ROWS) && ((c0 + c) < COLS);
            p.addr  = 13'(((r0 + r) % 64) * 128 + ((c0 + c) % 128));
            m_pix.push_back(p);
         end
      end
   endtask

   // compare DUT against the model each cycle, then advance the model
   always @(negedge Clock) begin
      cyc++;
      if (Reset) begin
         check("we_in_reset", 32'(bus.oVramWe), 32'(0));
      end else if (bus.iCpuWe) begin
         check("cpu_we", 32'(bus.oVramWe), 32'(1));
         check("cpu_addr", 32'(bus.oVramAddr), 32'(bus.iCpuAddr));
         check("cpu_data", 32'(bus.oVramData), 32'(bus.iCpuData));
      end else if (m_mode == 1 && m_idx < m_pix.size()) begin
         check("fill_we", 32'(bus.oVramWe), 32'(m_pix[m_idx].valid));
         if (m_pix[m_idx].valid) begin
            check("fill_addr", 32'(bus.oVramAddr), 32'(m_pix[m_idx].addr));
            check("fill_data", 32'(bus.oVramData), 32'(m_color));
         end
      end else if (m_mode == 0) begin
         check("idle_we", 32'(bus.oVramWe), 32'(0));
         check("idle_addr", 32'(bus.oVramAddr), 32'(0));
         check("idle_data", 32'(bus.oVramData), 32'(0));
      end else begin
         check("done_we", 32'(bus.oVramWe), 32'(0));
      end
      check("busy", 32'(bus.oBusy), 32'(m_mode != 0));
      check("done", 32'(bus.oDone), 32'(m_mode == 2));

      if (!Reset && bus.oVramWe === 1'b1 && !bus.iCpuWe) begin
         wlog.push_back(bus.oVramAddr);
         last_wr = cyc;
      end
      if (!Reset && bus.oVramWe === 1'b1 && bus.iCpuWe) cpu_cnt++;
      if (bus.oBusy === 1'b1) busy_cnt++;
      if (bus.oDone === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end

      if (Reset) begin
         m_mode = 0;
         m_pix.delete();
         m_idx = 0;
      end else begin
         case (m_mode)
            0: if (bus.iStart) begin
                  m_color = bus.iColor;
                  build_list(int'(bus.iRow0), int'(bus.iCol0), int'(bus.iHeight), int'(bus.iWidth));
                  m_idx  = 0;
                  m_mode = (m_pix.size() != 0) ? 1 : 2;
               end
            1: if (!bus.iCpuWe) begin
                  m_idx++;
                  if (m_idx >= m_pix.size()) m_mode = 2;
               end
            default: m_mode = 0;
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic set_idle();
      bus.iStart   = 1'b0;
      bus.iRow0    = '0;
      bus.iCol0    = '0;
      bus.iHeight  = '0;
      bus.iWidth   = '0;
      bus.iColor   = '0;
      bus.iCpuWe   = 1'b0;
      bus.iCpuAddr = '0;
      bus.iCpuData = '0;
   endtask

   task automatic clear_logs();
      wlog.delete();
      busy_cnt = 0;
      done_cnt = 0;
      cpu_cnt  = 0;
   endtask

   task automatic start_fill(input int r0, input int c0, input int h, input int w, input int color);
      bus.iRow0   = 6'(r0);
      bus.iCol0   = 7'(c0);
      bus.iHeight = 6'(h);
      bus.iWidth  = 7'(w);
      bus.iColor  = 3'(color);
      bus.iStart  = 1'b1;
      tick();
      bus.iStart  = 1'b0;
      // scramble parameters after the latch; they must be ignored
      bus.iRow0   = 6'($urandom);
      bus.iCol0   = 7'($urandom);
      bus.iHeight = 6'($urandom);
      bus.iWidth  = 7'($urandom);
      bus.iColor  = 3'($urandom);
   endtask

   task automatic wait_idle(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (bus.oBusy === 1'b0) break;
         tick();
      end
      check("wait_idle", 32'(bus.oBusy), 32'(0));
   endtask

   task automatic check_log(input string nm, input logic [12:0] exp[$]);
      check({nm, "_count"}, 32'(wlog.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < wlog.size(); i++)
         check({nm, "_addr"}, 32'(wlog[i]), 32'(exp[i]));
   endtask

   logic [12:0] exp_small[$];
   logic [12:0] exp_edge[$];
   logic [12:0] exp_none[$];

   initial begin
      exp_small = '{13'h103, 13'h104, 13'h105, 13'h183, 13'h184, 13'h185};
      exp_edge  = '{13'd7502, 13'd7503, 13'd7630, 13'd7631};
      exp_none  = {};

      // reset for two cycles, CPU strobe active in the first
      Reset = 1'b1;
      set_idle();
      bus.iCpuWe   = 1'b1;
      bus.iCpuAddr = 13'h1abc;
      bus.iCpuData = 3'd7;
      tick();
      bus.iCpuWe = 1'b0;
      tick();
      Reset = 1'b0;
      check("rst_busy", 32'(bus.oBusy), 32'(0));
      check("rst_done", 32'(bus.oDone), 32'(0));
      tick();

      // plain 2x3 fill
      clear_logs();
      start_fill(2, 3, 2, 3, 5);
      wait_idle(100);
      check_log("small", exp_small);
      check("small_busy_cycles", 32'(busy_cnt), 32'(7));
      check("small_done_count", 32'(done_cnt), 32'(1));
      check("small_done_after_last", 32'(done_cyc - last_wr), 32'(1));
      tick();

      // same fill with a two-cycle CPU burst mid-fill
      clear_logs();
      start_fill(2, 3, 2, 3, 5);
      tick();
      bus.iCpuWe   = 1'b1;
      bus.iCpuAddr = 13'h0105;
      bus.iCpuData = 3'd2;
      tick();
      tick();
      bus.iCpuWe = 1'b0;
      wait_idle(100);
      check_log("stall", exp_small);
      check("stall_cpu_writes", 32'(cpu_cnt), 32'(2));
      check("stall_busy_cycles", 32'(busy_cnt), 32'(9));
      tick();

      // rectangle hanging off the bottom-right corner
      clear_logs();
      start_fill(58, 78, 4, 4, 3);
      wait_idle(100);
      check_log("edge", exp_edge);
      check("edge_busy_cycles", 32'(busy_cnt), 32'(17));
      tick();

      // zero width, then zero height
      clear_logs();
      start_fill(10, 10, 5, 0, 1);
      wait_idle(10);
      check_log("w0", exp_none);
      check("w0_busy_cycles", 32'(busy_cnt), 32'(1));
      check("w0_done_count", 32'(done_cnt), 32'(1));
      clear_logs();
      start_fill(10, 10, 0, 5, 1);
      wait_idle(10);
      check_log("h0", exp_none);
      check("h0_busy_cycles", 32'(busy_cnt), 32'(1));
      tick();

      // reset after three fill writes
      clear_logs();
      start_fill(2, 3, 2, 3, 5);
      for (int k = 0; k < 50 && wlog.size() < 3; k++) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("abort_busy", 32'(bus.oBusy), 32'(0));
      for (int k = 0; k < 10; k++) tick();
      check("abort_writes", 32'(wlog.size()), 32'(3));
      check("abort_done_count", 32'(done_cnt), 32'(0));

      // iStart pulsed during FILL is ignored
      clear_logs();
      start_fill(2, 3, 2, 3, 5);
      tick();
      bus.iRow0   = 6'd20;
      bus.iCol0   = 7'd20;
      bus.iHeight = 6'd1;
      bus.iWidth  = 7'd1;
      bus.iStart  = 1'b1;
      tick();
      bus.iStart = 1'b0;
      wait_idle(100);
      check_log("restart", exp_small);
      check("restart_busy_cycles", 32'(busy_cnt), 32'(7));
      tick();

      // randomized traffic, checked cycle by cycle against the model
      for (int n = 0; n < 6000; n++) begin
         Reset        = ($urandom_range(0, 499) == 0);
         bus.iStart   = ($urandom_range(0, 3) == 0);
         bus.iRow0    = 6'($urandom);
         bus.iCol0    = 7'($urandom);
         if ($urandom_range(0, 49) == 0) begin
            bus.iHeight = 6'($urandom_range(0, 63));
            bus.iWidth  = 7'($urandom_range(0, 127));
         end else begin
            bus.iHeight = 6'($urandom_range(0, 6));
            bus.iWidth  = 7'($urandom_range(0, 10));
         end
         bus.iColor   = 3'($urandom);
         bus.iCpuWe   = ($urandom_range(0, 4) == 0);
         bus.iCpuAddr = 13'($urandom);
         bus.iCpuData = 3'($urandom);
         tick();
      end
      Reset = 1'b0;
      set_idle();
      wait_idle(20000);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
`default_nettype wire
